furv_dmem: RTL and testbench

- Data-side memory stage directly downstream of the furv core.
- Consumes the core's level-held request (mem, mem_write, addr, data_out) and produces data_in/read_ack.
- Decodes addr into a word RAM region and an MMIO region (TX byte FIFO, status, cycle counter).
- Runs on posedge clk; the core launches requests on negedge.

---
 rtl/furv_dmem_pkg.sv | 28 ++
 rtl/furv_dmem_if.sv | 20 ++
 rtl/furv_dmem_fifo.sv | 49 ++++
 rtl/furv_dmem.sv | 188 ++++++++++++++++++
 tb/tb_furv_dmem.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/furv_dmem_pkg.sv
// Shared types and constants for the furv data-memory stage:
// FSM states, the MMIO address map and the status register layout.
package furv_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RWAIT,
    ACK,
    WDONE
  } state_t;

  localparam logic [31:0] TX_ADDR   = 32'h8000_0000;
  localparam logic [31:0] STAT_ADDR = 32'h8000_0004;
  localparam logic [31:0] CYC_ADDR  = 32'h8000_0008;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 8;

  localparam logic [31:0] BUSERR_PATTERN = 32'hDEAD_BEEF;

  // The core only issues word accesses, so the byte offset is dropped before decoding.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/furv_dmem_if.sv
// Level-held request/response bus between the furv core (master)
// and the data-memory stage (slave).
interface furv_dmem_if;
  logic        mem;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        read_ack;

  modport master (
    output mem, mem_write, addr, data_out,
    input  data_in, read_ack
  );

  modport slave (
    input  mem, mem_write, addr, data_out,
    output data_in, read_ack
  );
endinterface

// File: rtl/furv_dmem_fifo.sv
// Parameterised synchronous FIFO; a pop frees the slot that a same-cycle
// push may fill, and the head reads as zero while the FIFO is empty.
module furv_dmem_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/furv_dmem.sv
// furv data-memory stage: word RAM plus MMIO (TX FIFO, status, cycle counter).
// Optional FURV_DMEM_BUSERR_EN adds a sticky bus_err output for out-of-range accesses.
module furv_dmem
  import furv_dmem_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  furv_dmem_if.slave  bus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef FURV_DMEM_BUSERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   ram [DEPTH];
  logic [31:0]   req_word;
  logic [31:0]   rd_addr;
  logic [31:0]   read_value;
  logic [31:0]   status_word;
  logic [31:0]   cycle_cnt;
  logic [2:0]    lat_cnt;
  logic          overflow;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;
  logic          do_write;
  logic          do_read_start;
  logic          raise_ack;
  logic          drop_ack;
  logic          ram_we;
  logic          push_req;
  logic          clr_ovf;

  assign req_word = word_align(bus.addr);

`ifdef FURV_DMEM_BUSERR_EN
  logic req_oob;
  logic rd_oob;
  logic addr_fault;

  assign req_oob = !bus.addr[31] && (bus.addr[30:AW+2] != '0);
  assign rd_oob  = !rd_addr[31] && (rd_addr[30:AW+2] != '0);
  assign addr_fault = (state == IDLE) && bus.mem &&
                      (req_oob || (bus.addr[31] && (req_word != TX_ADDR) &&
                       (req_word != STAT_ADDR) && (req_word != CYC_ADDR)));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // RWAIT leaves when the counter is about to hit zero, so read_ack
  // (raised on the first ACK edge) lands READ_LAT edges after sampling.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.mem) begin
          if (bus.mem_write)      state_nx = WDONE;
          else if (READ_LAT == 1) state_nx = ACK;
          else                    state_nx = RWAIT;
        end
      end
      RWAIT: begin
        if (!bus.mem)                 state_nx = IDLE;
        else if (lat_cnt == 3'd1)     state_nx = ACK;
      end
      ACK, WDONE: begin
        if (!bus.mem) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    do_write      = (state == IDLE) && bus.mem && bus.mem_write;
    do_read_start = (state == IDLE) && bus.mem && !bus.mem_write;
    raise_ack     = (state == ACK) && bus.mem && !bus.read_ack;
    drop_ack      = (state == ACK) && !bus.mem;
    push_req      = do_write && (req_word == TX_ADDR);
    clr_ovf       = raise_ack && (rd_addr == STAT_ADDR);
`ifdef FURV_DMEM_BUSERR_EN
    ram_we        = do_write && !bus.addr[31] && !req_oob;
`else
    ram_we        = do_write && !bus.addr[31];
`endif
  end

  always_comb begin
    status_word                      = '0;
    status_word[STAT_FULL_BIT]       = fifo_full;
    status_word[STAT_EMPTY_BIT]      = fifo_empty;
    status_word[STAT_OVF_BIT]        = overflow;
    status_word[STAT_CNT_LSB +: 4]   = 4'(fifo_count);

    read_value = '0;
    if (!rd_addr[31]) begin
      read_value = ram[rd_addr[AW+1:2]];
    end else begin
      case (rd_addr)
        STAT_ADDR: read_value = status_word;
        CYC_ADDR:  read_value = cycle_cnt;
        default:   read_value = '0;
      endcase
    end
`ifdef FURV_DMEM_BUSERR_EN
    if (rd_oob) read_value = BUSERR_PATTERN;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.read_ack <= 1'b0;
      bus.data_in  <= '0;
      rd_addr      <= '0;
      lat_cnt      <= '0;
    end else begin
      if (do_read_start) begin
        rd_addr <= req_word;
        lat_cnt <= 3'(READ_LAT - 1);
      end else if (state == RWAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (raise_ack) begin
        bus.read_ack <= 1'b1;
        bus.data_in  <= read_value;
      end else if (drop_ack) begin
        bus.read_ack <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[bus.addr[AW+1:2]] <= bus.data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end

  // A push into a full FIFO only counts as overflow if no pop frees a slot that edge.
  always_ff @(posedge clk) begin
    if (rst)                                     overflow <= 1'b0;
    else if (push_req && fifo_full && !fifo_pop) overflow <= 1'b1;
    else if (clr_ovf)                            overflow <= 1'b0;
  end

`ifdef FURV_DMEM_BUSERR_EN
  always_ff @(posedge clk) begin
    if (rst)             bus_err <= 1'b0;
    else if (addr_fault) bus_err <= 1'b1;
  end
`endif

  assign tx_valid = !fifo_empty;
  assign fifo_pop = tx_valid && tx_ready;

  furv_dmem_fifo #(
    .DEPTH(TX_DEPTH),
    .WIDTH(8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (bus.data_out[7:0]),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_furv_dmem.sv
// Scoreboard bench for furv_dmem: expected load data and TX bytes are queued
// when stimulus is driven and compared as read_ack / TX pops occur.
module tb_furv_dmem;
  import furv_dmem_pkg::*;

  localparam int DEPTH    = 1024;
  localparam int READ_LAT = 3;
  localparam int TX_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
`ifdef FURV_DMEM_BUSERR_EN
  logic       bus_err;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [31:0] expq[$];
  string       tagq[$];
  logic [7:0]  txq[$];
  logic [31:0] dummy;
  logic [31:0] got1;
  logic [31:0] got2;
  int          c0;
  logic        ack_seen;

  furv_dmem_if bus();

  furv_dmem #(
    .DEPTH(DEPTH),
    .READ_LAT(READ_LAT),
    .TX_DEPTH(TX_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
`ifdef FURV_DMEM_BUSERR_EN
    ,
    .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Loads wait (bounded) for read_ack, then pop the scoreboard when scoring is requested.
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input bit score, output logic [31:0] got);
    int lat;
    got = '0;
    @(negedge clk);
    bus.mem       = 1'b1;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.data_out  = d;
    if (wr) begin
      @(negedge clk);
      bus.mem = 1'b0;
    end else begin
      @(posedge clk);
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!bus.read_ack && lat < 20);
      checkOutput("ack_latency", 32'(lat), 32'(READ_LAT));
      got = bus.data_in;
      if (score) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL scoreboard: got 0x%08h expected an entry, queue empty", got);
        end else begin
          checkOutput(tagq.pop_front(), got, expq.pop_front());
        end
      end
      @(negedge clk);
      bus.mem = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ack_fall", 32'(bus.read_ack), 32'd0);
    end
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] g;
    expq.push_back(exp);
    tagq.push_back(tag);
    applyStimulus(1'b0, a, 32'd0, 1'b1, g);
  endtask

  task automatic tx_push(input logic [7:0] b);
    logic [31:0] g;
    applyStimulus(1'b1, TX_ADDR, {24'h0, b}, 1'b0, g);
    if (txq.size() < TX_DEPTH) txq.push_back(b);
  endtask

  task automatic drain_tx(input string tag);
    int n;
    logic [31:0] e;
    @(negedge clk);
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid && n < 4 * TX_DEPTH) begin
      if (txq.size() != 0) e = {24'h0, txq.pop_front()};
      else                 e = 32'hFFFF_FFFF;
      checkOutput(tag, {24'h0, tx_data}, e);
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    checkOutput("tx_left", 32'(txq.size()), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    tx_ready      = 1'b0;
    bus.mem       = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.data_out  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_read_ack", 32'(bus.read_ack), 32'd0);
    checkOutput("rst_data_in", bus.data_in, 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", {24'h0, tx_data}, 32'd0);
`ifdef FURV_DMEM_BUSERR_EN
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
`endif

    applyStimulus(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, dummy);
    load_check("ram_rd", 32'h0000_0010, 32'h1234_5678);

    tx_push(8'h41);
    load_check("stat_one", STAT_ADDR, 32'h0000_0100);
    @(negedge clk);
    checkOutput("tx_valid_one", 32'(tx_valid), 32'd1);
    checkOutput("tx_data_one", {24'h0, tx_data}, 32'h41);
    drain_tx("tx_a");
    load_check("stat_empty", STAT_ADDR, 32'h0000_0002);

    for (int i = 0; i < 9; i++) tx_push(8'(8'h30 + i));
    load_check("stat_ovf", STAT_ADDR, 32'h0000_0805);
    load_check("stat_ovf_clr", STAT_ADDR, 32'h0000_0801);
    @(negedge clk);
    checkOutput("tx_head_full", {24'h0, tx_data}, 32'h30);

    // Push and pop on the same edge while full: accepted, no overflow.
    tx_ready      = 1'b1;
    bus.mem       = 1'b1;
    bus.mem_write = 1'b1;
    bus.addr      = TX_ADDR;
    bus.data_out  = 32'h50;
    void'(txq.pop_front());
    txq.push_back(8'h50);
    @(negedge clk);
    tx_ready = 1'b0;
    bus.mem  = 1'b0;
    load_check("stat_pp_full", STAT_ADDR, 32'h0000_0801);
    drain_tx("tx_drain");

    // Push with pop requested while empty: push wins, tx_valid follows.
    @(negedge clk);
    tx_ready      = 1'b1;
    bus.mem       = 1'b1;
    bus.mem_write = 1'b1;
    bus.addr      = TX_ADDR;
    bus.data_out  = 32'h5A;
    txq.push_back(8'h5A);
    @(negedge clk);
    tx_ready = 1'b0;
    bus.mem  = 1'b0;
    checkOutput("tx_pp_empty_valid", 32'(tx_valid), 32'd1);
    checkOutput("tx_pp_empty_data", {24'h0, tx_data}, 32'h5A);
    drain_tx("tx_pp_empty");

    // Held store: only the first edge commits.
    @(negedge clk);
    bus.mem       = 1'b1;
    bus.mem_write = 1'b1;
    bus.addr      = 32'h0000_0020;
    bus.data_out  = 32'd5;
    @(negedge clk);
    bus.data_out  = 32'd6;
    @(negedge clk);
    @(negedge clk);
    bus.mem = 1'b0;
    load_check("wdone_once", 32'h0000_0020, 32'd5);

    load_check("tx_read_zero", TX_ADDR, 32'd0);
    load_check("unmapped_zero", 32'h8000_000C, 32'd0);

    c0 = cyc;
    applyStimulus(1'b0, CYC_ADDR, 32'd0, 1'b0, got1);
    while (cyc < c0 + 10) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, CYC_ADDR, 32'd0, 1'b0, got2);
    checkOutput("cyc_delta", got2 - got1, 32'd10);

    // Reset during RWAIT: no ack, FIFO cleared, RAM retained.
    tx_push(8'h77);
    txq.delete();
    @(negedge clk);
    bus.mem       = 1'b1;
    bus.mem_write = 1'b0;
    bus.addr      = 32'h0000_0010;
    @(posedge clk);
    #1;
    checkOutput("rwait_no_ack", 32'(bus.read_ack), 32'd0);
    @(negedge clk);
    rst     = 1'b1;
    bus.mem = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_ack", 32'(bus.read_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      ack_seen = ack_seen | bus.read_ack;
    end
    checkOutput("rst_no_late_ack", 32'(ack_seen), 32'd0);
    checkOutput("rst_tx_cleared", 32'(tx_valid), 32'd0);
    load_check("rst_ram_kept", 32'h0000_0010, 32'h1234_5678);
    load_check("rst_stat", STAT_ADDR, 32'h0000_0002);

`ifdef FURV_DMEM_BUSERR_EN
    checkOutput("bus_err_clear", 32'(bus_err), 32'd0);
    load_check("oob_pattern", 32'h0000_1010, BUSERR_PATTERN);
    checkOutput("bus_err_set", 32'(bus_err), 32'd1);
`else
    load_check("ram_wrap", 32'h0000_1010, 32'h1234_5678);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
